// File: rtl/tap_recorder.sv
// rtl/tap_recorder.sv - records the cassette write line as a TAP v1 image
// Pulse periods are measured in CPU ticks and written one byte at a time over a req/ack port.
module tap_recorder #(
    parameter logic [24:0] BASE_ADDR = 25'h0000000,
    parameter logic [23:0] MAX_BYTES = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        enable,
    input  logic        cass_motor_n,
    input  logic        cass_write,
    output logic        wr_req,
    output logic [24:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic [23:0] tap_len,
    output logic        active,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_ARM, S_RUN, S_EMIT, S_FIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] grp_q, grp_d;
    logic [1:0]  last_q, last_d;
    logic [23:0] len_q, len_d;
    logic [23:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        stop_q, stop_d;
    logic        en_prev_q;
    logic        s1_q, s2_q, prev_q;

    logic        edge_w, tick_w, long_w, fits_w, accept_w;
    logic [7:0]  short_w;
    logic [31:0] enc_w;

    function automatic logic [7:0] hdr_byte(input logic [4:0] i);
        case (i)
            5'd0:    hdr_byte = 8'h43;
            5'd1:    hdr_byte = 8'h36;
            5'd2:    hdr_byte = 8'h34;
            5'd3:    hdr_byte = 8'h2D;
            5'd4:    hdr_byte = 8'h54;
            5'd5:    hdr_byte = 8'h41;
            5'd6:    hdr_byte = 8'h50;
            5'd7:    hdr_byte = 8'h45;
            5'd8:    hdr_byte = 8'h2D;
            5'd9:    hdr_byte = 8'h52;
            5'd10:   hdr_byte = 8'h41;
            5'd11:   hdr_byte = 8'h57;
            5'd12:   hdr_byte = 8'h01;
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    assign edge_w   = s2_q & ~prev_q;
    assign tick_w   = ce_1m & ~cass_motor_n;
    assign long_w   = |cnt_q[23:11];
    assign short_w  = (cnt_q[10:3] == 8'h00) ? 8'h01 : cnt_q[10:3];
    // Byte 0 of the group sits in the low lane so EMIT can index by idx_q.
    assign enc_w    = long_w ? {cnt_q[23:16], cnt_q[15:8], cnt_q[7:0], 8'h00} : {24'h000000, short_w};
    assign fits_w   = ({1'b0, len_q} + (long_w ? 25'd4 : 25'd1)) <= {1'b0, MAX_BYTES};
    assign accept_w = wr_req & wr_ack;

    assign tap_len  = len_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign active   = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        cnt_d = cnt_q;
        if (edge_w)
            cnt_d = tick_w ? 24'd1 : 24'd0;
        else if (state_q == S_ARM)
            cnt_d = 24'd0;
        else if (tick_w && cnt_q != 24'hFFFFFF)
            cnt_d = cnt_q + 24'd1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grp_d   = grp_q;
        last_d  = last_q;
        len_d   = len_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        stop_d  = stop_q;
        wr_req  = 1'b0;
        wr_addr = BASE_ADDR;
        wr_data = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (enable && !en_prev_q) begin
                    len_d   = 24'd0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    stop_d  = 1'b0;
                    idx_d   = 5'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                wr_req  = 1'b1;
                wr_addr = BASE_ADDR + 25'(idx_q);
                wr_data = hdr_byte(idx_q);
                if (!enable) stop_d = 1'b1;
                if (accept_w) begin
                    if (idx_q == 5'd19) begin
                        idx_d   = 5'd0;
                        state_d = (stop_q || !enable) ? S_FIN : S_ARM;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_ARM: begin
                if (!enable) begin
                    idx_d   = 5'd0;
                    state_d = S_FIN;
                end else if (edge_w) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    idx_d   = 5'd0;
                    state_d = S_FIN;
                end else if (edge_w) begin
                    idx_d = 5'd0;
                    if (fits_w) begin
                        grp_d   = enc_w;
                        last_d  = long_w ? 2'd3 : 2'd0;
                        state_d = S_EMIT;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_EMIT: begin
                wr_req  = 1'b1;
                wr_addr = BASE_ADDR + 25'd20 + {1'b0, len_q};
                wr_data = grp_q[{idx_q[1:0], 3'b000} +: 8];
                if (!enable) stop_d = 1'b1;
                if (edge_w) ovf_d = 1'b1;
                if (accept_w) begin
                    len_d = len_q + 24'd1;
                    if (idx_q[1:0] == last_q) begin
                        idx_d   = 5'd0;
                        state_d = (stop_q || !enable) ? S_FIN : S_RUN;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_FIN: begin
                wr_req  = 1'b1;
                wr_addr = BASE_ADDR + 25'd16 + 25'(idx_q);
                case (idx_q[1:0])
                    2'd0:    wr_data = len_q[7:0];
                    2'd1:    wr_data = len_q[15:8];
                    2'd2:    wr_data = len_q[23:16];
                    default: wr_data = 8'h00;
                endcase
                if (accept_w) begin
                    if (idx_q[1:0] == 2'd3) begin
                        idx_d   = 5'd0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 5'd0;
            grp_q     <= 32'd0;
            last_q    <= 2'd0;
            len_q     <= 24'd0;
            cnt_q     <= 24'd0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            stop_q    <= 1'b0;
            en_prev_q <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            grp_q     <= grp_d;
            last_q    <= last_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            stop_q    <= stop_d;
            en_prev_q <= enable;
            s1_q      <= cass_write;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
        end
    end

endmodule

// File: doc/tap_recorder.md
Name: tap_recorder

Overview:
- Records the PET cassette write line (`cass_write` from pet2001hw) into a TAP v1 image in SDRAM.
- It is the write-side counterpart of the tape player: it measures pulse periods in CPU-clock ticks and encodes them as TAP bytes.
- It emits a 20-byte header and, on stop, patches the length field at header offsets 16..19.
- It sits beside `tape` and masters the sram write port through a req/ack byte handshake; the image can then be uploaded to the host.

Parameters:
- BASE_ADDR, 25'h0000000: SDRAM byte address of the first header byte.
- MAX_BYTES, 24'hFFFFFF: maximum number of data bytes (excluding the header) before overflow.

Ports:
- clk, input, 1: system clock (112 MHz). Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- ce_1m, input, 1: CPU clock enable, one clk-cycle pulse per tick.
- enable, input, 1: record arm, level. Rising edge starts a recording; falling edge stops it.
- cass_motor_n, input, 1: active-low motor. The tick counter advances only while it is 0.
- cass_write, input, 1: PET tape output level (asynchronous; synchronized internally).
- wr_req, output, 1: byte write request.
- wr_addr, output, 25: write address, stable while wr_req=1.
- wr_data, output, 8: write data, stable while wr_req=1.
- wr_ack, input, 1: the byte is accepted in any clk where wr_req&wr_ack=1.
- tap_len, output, 24: number of data bytes written so far.
- active, output, 1: high from the start of the header until the end of the length patch.
- done, output, 1: high once the length patch completes; cleared by the next start.
- overflow, output, 1: sticky; cleared by the next start.

Behaviour:
- Reset values: wr_req=0, wr_addr=BASE_ADDR, wr_data=0, tap_len=0, active=0, done=0, overflow=0; FSM=IDLE.
  - Reset mid-write drops wr_req immediately; no partial sequence resumes after reset.
- Input conditioning: `cass_write` passes through a 2-flop synchronizer. A rising edge is detected on the synchronized signal (sync=1, previous=0).
- Tick counter `cnt` (24 bits, saturating at 24'hFFFFFF):
  - Increments on ce_1m when cass_motor_n=0.
  - On a rising edge, the pulse value P = cnt (value before this cycle's update).
  - On an edge, cnt loads 1 if a qualifying tick occurs in the same cycle, else 0.
- Encoding of P:
  - If P[23:11]!=0 (P>=2048): long form, 4 bytes: 8'h00, P[7:0], P[15:8], P[23:16].
  - Otherwise short form, 1 byte: P[10:3], forced to 8'h01 if the result is 0.
- FSM states:
  - IDLE: on enable 0->1, clear tap_len, done and overflow; set active; enter HDR.
  - HDR: write 20 bytes at BASE_ADDR+0..19: ASCII "C64-TAPE-RAW", 8'h01, 8'h00 x3, 8'h00 x4. Then enter ARM.
  - ARM: reset cnt to 0. On the first rising edge emit nothing and enter RUN; the counter starts from the edge.
  - RUN: on each rising edge latch the encoded bytes and enter EMIT.
  - EMIT: write 1 or 4 bytes at BASE_ADDR+20+tap_len, incrementing tap_len per accepted byte. Then return to RUN.
  - FIN: write tap_len as 4 bytes little-endian at BASE_ADDR+16..19, with byte 19 = 8'h00. Then enter DONE.
  - DONE: active=0, done=1. Return to IDLE when enable=0.
- Handshake:
  - The next byte's wr_req/addr/data are presented in the cycle after an accept.
  - wr_req stays asserted with stable address and data until accepted.
  - Only one outstanding byte at a time.
- Stop:
  - enable=0 in ARM or RUN enters FIN.
  - enable=0 in HDR completes the header first, then enters FIN.
  - enable=0 in EMIT completes the current 1- or 4-byte group, then enters FIN.
  - The pulse in progress at stop is discarded.
- Edge during EMIT: the edge is dropped, overflow=1, and cnt restarts per the edge rule.
- Capacity: if tap_len + group size would exceed MAX_BYTES, the group is not written, overflow=1, and the FSM enters FIN.
  - A long-form group is never split.
- enable rising while in HDR, ARM, RUN, EMIT or FIN is ignored.

Test Plan:
- Start, then ack every request immediately -> 20 header writes at addr 0..19 with bytes "C64-TAPE-RAW",01,00,00,00,00,00,00,00.
- Edges at 400-tick spacing (motor on) -> first edge emits nothing; each later edge emits 8'h32 at addr 20,21,...; tap_len increments by 1.
- Pulse of 3000 ticks -> bytes 00,B8,0B,00 at consecutive addresses; tap_len += 4. Pulse of 5 ticks -> byte 01.
- Stop after 3 short and 1 long pulse -> patch writes at addr 16..19 = 07,00,00,00; then done=1, active=0. Hold wr_ack low 10 cycles mid-patch -> addr and data stay stable.
- MAX_BYTES=5, then a 3000-tick pulse after 2 data bytes -> no write for that group; overflow=1; patch = 02,00,00,00. Motor off for 1000 ticks inside a pulse -> those ticks are excluded from P.
- Assert reset during an EMIT with wr_req=1 -> all outputs return to reset values the same cycle; the next enable rise restarts from the header.
